// File: rtl/ram_sdp.sv
// Simple dual-port RAM (one write port, one read port) with byte enables, an optional output register,
// and a clear engine that zeroes the array after reset or on request.
//   state   | meaning
//   S_IDLE  | ports live; clr_req starts a clear
//   S_CLEAR | mem[ptr] <= 0 each cycle, ports locked out
module ram_sdp #(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 1024,
    parameter int ADDR_W  = $clog2(DEPTH),
    parameter int RD_MODE = 0,
    parameter int OUT_REG = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr_req,
    output logic                clr_busy,
    output logic                clr_done,
    input  logic                wr_cs_n,
    input  logic [DATA_W/8-1:0] wr_be,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                rd_cs_n,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_valid
);

    localparam int NB = DATA_W / 8;
    // One extra bit so that DEPTH == 2**ADDR_W does not wrap to zero.
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic                clr_done_q, clr_done_d;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic                wr_en, rd_launch, wr_in_range, rd_in_range;
    logic [DATA_W-1:0]   rd_word;
    logic                rd_v1_q;
    logic [DATA_W-1:0]   rd_d1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_CLEAR;
            ptr_q      <= '0;
            clr_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            clr_done_q <= clr_done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        clr_done_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (clr_req) begin
                    state_d = S_CLEAR;
                    ptr_d   = '0;
                end
            end
            S_CLEAR: begin
                if (ptr_q == LAST_ADDR) begin
                    state_d    = S_IDLE;
                    ptr_d      = '0;
                    clr_done_d = 1'b1;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign clr_busy = (state_q == S_CLEAR);
    assign clr_done = clr_done_q;

    assign wr_in_range = ({1'b0, wr_addr} < DEPTH_EXT);
    assign rd_in_range = ({1'b0, rd_addr} < DEPTH_EXT);
    assign wr_en       = !wr_cs_n && !clr_busy && wr_in_range;
    assign rd_launch   = !rd_cs_n && !clr_busy;

    // The array has no reset; the clear engine is its only initialiser.
    always_ff @(posedge clk) begin
        if (clr_busy) begin
            mem[ptr_q] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_be[i]) mem[wr_addr][i*8 +: 8] <= wr_data[i*8 +: 8];
            end
        end
    end

    always_comb begin
        rd_word = rd_in_range ? mem[rd_addr] : '0;
        if (RD_MODE == 1 && wr_en && wr_addr == rd_addr) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_be[i]) rd_word[i*8 +: 8] = wr_data[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_v1_q <= 1'b0;
            rd_d1_q <= '0;
        end else begin
            rd_v1_q <= rd_launch;
            if (rd_launch) rd_d1_q <= rd_word;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic              rd_v2_q;
            logic [DATA_W-1:0] rd_d2_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_v2_q <= 1'b0;
                    rd_d2_q <= '0;
                end else begin
                    rd_v2_q <= rd_v1_q;
                    if (rd_v1_q) rd_d2_q <= rd_d1_q;
                end
            end

            assign rd_valid = rd_v2_q;
            assign rd_data  = rd_d2_q;
        end else begin : g_no_out_reg
            assign rd_valid = rd_v1_q;
            assign rd_data  = rd_d1_q;
        end
    endgenerate

endmodule

// File: tb/tb_ram_sdp.sv
// Bench for ram_sdp: instance 0 is the default build (read-first, no output register, 1024 words);
// instance 1 is write-through, output-registered, 1000 words. A monitor scoreboards every rd_valid.
module tb_ram_sdp;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic [1:0]       clr_req = '0;
    logic [1:0]       clr_busy, clr_done, rd_valid;
    logic [1:0]       wr_cs_n = '1;
    logic [1:0]       rd_cs_n = '1;
    logic [1:0][3:0]  wr_be   = '0;
    logic [1:0][9:0]  wr_addr = '0;
    logic [1:0][9:0]  rd_addr = '0;
    logic [1:0][31:0] wr_data = '0;
    logic [1:0][31:0] rd_data;

    int cyc   = 0;
    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic [31:0] d;
        int          c;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [31:0] last_d [2];

    ram_sdp #(.DATA_W(32), .DEPTH(1024), .RD_MODE(0), .OUT_REG(0)) u0 (
        .clk(clk), .rst_n(rst_n), .clr_req(clr_req[0]), .clr_busy(clr_busy[0]), .clr_done(clr_done[0]),
        .wr_cs_n(wr_cs_n[0]), .wr_be(wr_be[0]), .wr_addr(wr_addr[0]), .wr_data(wr_data[0]),
        .rd_cs_n(rd_cs_n[0]), .rd_addr(rd_addr[0]), .rd_data(rd_data[0]), .rd_valid(rd_valid[0])
    );

    ram_sdp #(.DATA_W(32), .DEPTH(1000), .RD_MODE(1), .OUT_REG(1)) u1 (
        .clk(clk), .rst_n(rst_n), .clr_req(clr_req[1]), .clr_busy(clr_busy[1]), .clr_done(clr_done[1]),
        .wr_cs_n(wr_cs_n[1]), .wr_be(wr_be[1]), .wr_addr(wr_addr[1]), .wr_data(wr_data[1]),
        .rd_cs_n(rd_cs_n[1]), .rd_addr(rd_addr[1]), .rd_data(rd_data[1]), .rd_valid(rd_valid[1])
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one cycle on port k; when expv is set the expected read result is queued.
    task automatic issue(input int k, input bit rd, input logic [9:0] ra, input bit expv,
                         input logic [31:0] ed, input bit wr, input logic [9:0] wa,
                         input logic [31:0] wd, input logic [3:0] be);
        exp_t e;
        rd_cs_n[k] = !rd;
        rd_addr[k] = ra;
        wr_cs_n[k] = !wr;
        wr_addr[k] = wa;
        wr_data[k] = wd;
        wr_be[k]   = be;
        if (expv) begin
            e.d = ed;
            e.c = cyc + 1 + ((k == 1) ? 1 : 0);
            if (k == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
        tick();
    endtask

    task automatic wr(input int k, input logic [9:0] a, input logic [31:0] d, input logic [3:0] be);
        issue(k, 1'b0, 10'd0, 1'b0, 32'd0, 1'b1, a, d, be);
    endtask

    task automatic rd(input int k, input logic [9:0] a, input logic [31:0] e);
        issue(k, 1'b1, a, 1'b1, e, 1'b0, 10'd0, 32'd0, 4'd0);
    endtask

    task automatic idle(input int k);
        rd_cs_n[k] = 1'b1;
        wr_cs_n[k] = 1'b1;
    endtask

    task automatic mon_port(input int k);
        exp_t e;
        bit   empty;
        empty = (k == 0) ? (q0.size() == 0) : (q1.size() == 0);
        if (rd_valid[k]) begin
            if (empty) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_rd_valid[%0d]: got rd_valid=1 data %h at cycle %0d, required no result",
                         k, rd_data[k], cyc);
            end else begin
                if (k == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                chk($sformatf("rd_data[%0d]", k), rd_data[k], e.d);
                chk($sformatf("rd_cycle[%0d]", k), cyc, e.c);
                last_d[k] = rd_data[k];
            end
        end else begin
            chk($sformatf("rd_hold[%0d]", k), rd_data[k], last_d[k]);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                last_d[0] = '0;
                last_d[1] = '0;
            end else begin
                mon_port(0);
                mon_port(1);
            end
        end
    end

    // Applies reset, releases it, and times the automatic clear on both instances.
    task automatic run_reset_clear();
        int first [2];
        int dcnt  [2];
        bit early [2];
        rst_n = 1'b0;
        tick();
        tick();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_busy[%0d]", k), clr_busy[k], 1);
            chk($sformatf("rst_done[%0d]", k), clr_done[k], 0);
            chk($sformatf("rst_valid[%0d]", k), rd_valid[k], 0);
            chk($sformatf("rst_data[%0d]", k), rd_data[k], 0);
            first[k] = 0;
            dcnt[k]  = 0;
            early[k] = 1'b0;
        end
        rst_n = 1'b1;
        for (int i = 1; i <= 1100; i++) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                if (clr_done[k]) begin
                    dcnt[k]++;
                    if (first[k] == 0) first[k] = i;
                end else if (!clr_busy[k] && first[k] == 0) begin
                    early[k] = 1'b1;
                end
            end
        end
        chk("clr_cycles[0]", first[0], 1024);
        chk("clr_cycles[1]", first[1], 1000);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("done_pulses[%0d]", k), dcnt[k], 1);
            chk($sformatf("busy_early_drop[%0d]", k), early[k], 0);
            chk($sformatf("busy_after[%0d]", k), clr_busy[k], 0);
        end
    endtask

    task automatic wait_done(input int k, input int n0, input int exp_n);
        int n     = n0;
        bit seen  = 1'b0;
        bit early = 1'b0;
        while (n < 3000 && !seen) begin
            tick();
            n++;
            if (clr_done[k]) seen = 1'b1;
            else if (!clr_busy[k]) early = 1'b1;
        end
        chk("req_clr_done_seen", seen, 1);
        chk("req_clr_cycles", n, exp_n);
        chk("req_busy_held", early, 0);
        chk("req_busy_fell", clr_busy[k], 0);
        tick();
        chk("req_done_single", clr_done[k], 0);
    endtask

    initial begin
        int n;
        run_reset_clear();

        // Array is zero after the power-up clear, including both boundaries.
        rd(0, 10'd0, 32'h0);
        rd(0, 10'd511, 32'h0);
        rd(0, 10'd1023, 32'h0);
        idle(0);
        rd(1, 10'd0, 32'h0);
        rd(1, 10'd999, 32'h0);
        idle(1);
        repeat (3) tick();

        // Byte enables.
        wr(0, 10'd5, 32'hAABBCCDD, 4'hF);
        wr(0, 10'd5, 32'h11223344, 4'b0101);
        rd(0, 10'd5, 32'hAA22CC44);
        idle(0);
        tick();

        // Collisions: read-first on instance 0, write-through (full and partial) on instance 1.
        issue(0, 1'b1, 10'd7, 1'b1, 32'h00000000, 1'b1, 10'd7, 32'hDEADBEEF, 4'hF);
        rd(0, 10'd7, 32'hDEADBEEF);
        idle(0);
        issue(1, 1'b1, 10'd7, 1'b1, 32'hDEADBEEF, 1'b1, 10'd7, 32'hDEADBEEF, 4'hF);
        issue(1, 1'b1, 10'd8, 1'b1, 32'h00005678, 1'b1, 10'd8, 32'h12345678, 4'b0011);
        rd(1, 10'd7, 32'hDEADBEEF);
        rd(1, 10'd8, 32'h00005678);
        idle(1);
        repeat (3) tick();

        // Streaming through the output register.
        for (int i = 0; i < 8; i++) wr(1, 10'(i), 32'h100 + 32'(i), 4'hF);
        for (int i = 0; i < 8; i++) rd(1, 10'(i), 32'h100 + 32'(i));
        idle(1);
        repeat (3) tick();

        // Out of range on the 1000-word instance; last word is still writable.
        wr(1, 10'd1010, 32'hCAFEF00D, 4'hF);
        wr(1, 10'd999, 32'h00000055, 4'hF);
        rd(1, 10'd1010, 32'h0);
        rd(1, 10'd999, 32'h00000055);
        idle(1);
        repeat (3) tick();

        // Requested clear with lockout; a read launched alongside the request still completes.
        clr_req[0] = 1'b1;
        rd(0, 10'd5, 32'hAA22CC44);
        idle(0);
        n = 1;
        chk("req_busy_rise", clr_busy[0], 1);
        repeat (4) tick();
        n += 4;
        clr_req[0] = 1'b0;
        repeat (95) tick();
        n += 95;
        wr(0, 10'd3, 32'h33333333, 4'hF);
        n++;
        issue(0, 1'b1, 10'd3, 1'b0, 32'd0, 1'b0, 10'd0, 32'd0, 4'd0);
        n++;
        idle(0);
        wait_done(0, n, 1025);
        rd(0, 10'd3, 32'h0);
        rd(0, 10'd5, 32'h0);
        idle(0);
        repeat (3) tick();

        // Reset in the middle of a clear restarts it from the beginning.
        clr_req[0] = 1'b1;
        tick();
        clr_req[0] = 1'b0;
        repeat (300) tick();
        chk("midclr_busy", clr_busy[0], 1);
        run_reset_clear();
        rd(0, 10'd5, 32'h0);
        idle(0);
        rd(1, 10'd999, 32'h0);
        rd(1, 10'd3, 32'h0);
        rd(1, 10'd1010, 32'h0);
        idle(1);
        repeat (5) tick();

        chk("pending_results[0]", q0.size(), 0);
        chk("pending_results[1]", q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
